// File: rtl/uart_rx_framed.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_framed
// Description : Oversampling UART receiver with a two-flop input synchroniser,
//               configurable data width, parity and stop bits, plus error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_framed #(
    parameter int CLKS_PER_BIT = 2813,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int C_HALF = CLKS_PER_BIT / 2;
    localparam int C_CW   = $clog2(CLKS_PER_BIT);

    localparam logic [C_CW-1:0] C_HALF_END  = C_CW'(C_HALF - 1);
    localparam logic [C_CW-1:0] C_BIT_END   = C_CW'(CLKS_PER_BIT - 1);
    localparam logic [C_CW-1:0] C_CNT_ONE   = C_CW'(1);
    localparam logic [3:0]      C_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      C_STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    logic                 r_sync1;
    logic                 r_sync2;
    state_t               r_state;
    logic [C_CW-1:0]      r_cnt;
    logic [3:0]           r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_ferr;

    state_t               w_state_n;
    logic [C_CW-1:0]      w_cnt_n;
    logic [3:0]           w_idx_n;
    logic [DATA_BITS-1:0] w_shift_n;
    logic                 w_par_n;
    logic                 w_ferr_n;
    logic [DATA_BITS-1:0] w_dout_n;
    logic                 w_perr_n;
    logic                 w_frm_n;
    logic                 w_valid_n;
    logic                 w_rx_s;
    logic                 w_tick;
    logic                 w_stop_ferr;
    logic                 w_par_err;

    assign w_rx_s      = r_sync2;
    assign w_tick      = (r_cnt == C_BIT_END);
    assign w_stop_ferr = r_ferr | ~w_rx_s;
    assign busy        = (r_state != S_IDLE);

    // r_par holds XOR of all data bits and the received parity bit
    always_comb begin
        w_par_err = 1'b0;
        if (PARITY == 1) begin
            w_par_err = ~r_par;
        end else if (PARITY == 2) begin
            w_par_err = r_par;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_ferr     <= 1'b0;
            data_out   <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            r_sync1    <= rx;
            r_sync2    <= r_sync1;
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_idx      <= w_idx_n;
            r_shift    <= w_shift_n;
            r_par      <= w_par_n;
            r_ferr     <= w_ferr_n;
            data_out   <= w_dout_n;
            parity_err <= w_perr_n;
            frame_err  <= w_frm_n;
            data_valid <= w_valid_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_idx_n   = r_idx;
        w_shift_n = r_shift;
        w_par_n   = r_par;
        w_ferr_n  = r_ferr;
        w_dout_n  = data_out;
        w_perr_n  = parity_err;
        w_frm_n   = frame_err;
        w_valid_n = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_n = S_START;
                    w_cnt_n   = '0;
                end
            end

            S_START: begin
                if (r_cnt == C_HALF_END) begin
                    if (!w_rx_s) begin
                        w_state_n = S_DATA;
                        w_cnt_n   = '0;
                        w_idx_n   = '0;
                        w_par_n   = 1'b0;
                        w_ferr_n  = 1'b0;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end else begin
                    w_cnt_n = r_cnt + C_CNT_ONE;
                end
            end

            S_DATA: begin
                if (w_tick) begin
                    w_cnt_n   = '0;
                    w_shift_n = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    w_par_n   = r_par ^ w_rx_s;
                    if (r_idx == C_DATA_LAST) begin
                        w_idx_n   = '0;
                        w_state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_idx_n = r_idx + 4'd1;
                    end
                end else begin
                    w_cnt_n = r_cnt + C_CNT_ONE;
                end
            end

            S_PARITY: begin
                if (w_tick) begin
                    w_cnt_n   = '0;
                    w_par_n   = r_par ^ w_rx_s;
                    w_state_n = S_STOP;
                end else begin
                    w_cnt_n = r_cnt + C_CNT_ONE;
                end
            end

            S_STOP: begin
                if (w_tick) begin
                    w_cnt_n = '0;
                    if (r_idx == C_STOP_LAST) begin
                        // Leave mid stop bit so a zero-gap start bit is still seen
                        w_idx_n   = '0;
                        w_dout_n  = r_shift;
                        w_perr_n  = w_par_err;
                        w_frm_n   = w_stop_ferr;
                        w_valid_n = 1'b1;
                        w_state_n = w_stop_ferr ? S_BREAK : S_IDLE;
                    end else begin
                        w_ferr_n = w_stop_ferr;
                        w_idx_n  = r_idx + 4'd1;
                    end
                end else begin
                    w_cnt_n = r_cnt + C_CNT_ONE;
                end
            end

            S_BREAK: begin
                if (w_rx_s) begin
                    w_state_n = S_IDLE;
                end
            end

            default: begin
                w_state_n = S_IDLE;
                w_cnt_n   = '0;
                w_idx_n   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire
